// File: rtl/class_sum_argmax.sv
// Class-sum accumulator with serial signed argmax over CLASSN classes.
// Ports: clk/rst (sync, active-high), img_rst, clause_valid/op/idx/last,
//   w_we/w_addr/w_data weight writes, result_ready/result_valid/pred_class/
//   pred_sum result handshake, busy, drop_err. Optional saturation:
//   define CLASS_SUM_SAT_EN (default build wraps modulo 2^SUM_WIDTH).
module class_sum_argmax #(
  parameter int CLAUSEN   = 10,
  parameter int CLASSN    = 5,
  parameter int W_WIDTH   = 8,
  parameter int SUM_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          img_rst,
  input  logic                          clause_valid,
  input  logic                          clause_op,
  input  logic [$clog2(CLAUSEN)-1:0]    clause_idx,
  input  logic                          last_clause,
  input  logic                          w_we,
  input  logic [$clog2(CLAUSEN)-1:0]    w_addr,
  input  logic [CLASSN*W_WIDTH-1:0]     w_data,
  input  logic                          result_ready,
  output logic                          result_valid,
  output logic [$clog2(CLASSN)-1:0]     pred_class,
  output logic signed [SUM_WIDTH-1:0]   pred_sum,
  output logic                          busy,
  output logic                          drop_err
);

  localparam int CW = $clog2(CLASSN);
  localparam int RW = CLASSN * W_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    ARGMAX,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [RW-1:0]               wmem [CLAUSEN];
  logic signed [SUM_WIDTH-1:0] sums [CLASSN];
  logic [RW-1:0]               row;
  logic [CW-1:0]               scan_idx;
  logic [CW-1:0]               best_class;
  logic signed [SUM_WIDTH-1:0] best_sum;

  function automatic logic signed [SUM_WIDTH-1:0] acc(
    input logic signed [SUM_WIDTH-1:0] s,
    input logic signed [W_WIDTH-1:0]   w
  );
    logic [SUM_WIDTH:0] t;
    t = {s[SUM_WIDTH-1], s}
      + {{(SUM_WIDTH+1-W_WIDTH){w[W_WIDTH-1]}}, w};
`ifdef CLASS_SUM_SAT_EN
    // Sign mismatch between the guard bit and the MSB means overflow.
    if (t[SUM_WIDTH] != t[SUM_WIDTH-1])
      acc = t[SUM_WIDTH] ? {1'b1, {(SUM_WIDTH-1){1'b0}}}
                         : {1'b0, {(SUM_WIDTH-1){1'b1}}};
    else
      acc = t[SUM_WIDTH-1:0];
`else
    acc = t[SUM_WIDTH-1:0];
`endif
  endfunction

  // Out-of-range clause index reads as an all-zero weight row.
  always_comb begin
    row = '0;
    if (32'(clause_idx) < CLAUSEN)
      row = wmem[clause_idx];
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   state_n = IDLE;
      ACCUM:  if (clause_valid && last_clause) state_n = ARGMAX;
      ARGMAX: if (scan_idx == CW'(CLASSN-1)) state_n = DONE;
      DONE:   if (result_valid && result_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (img_rst) state_n = ACCUM;
  end

  assign busy = (state == ACCUM) || (state == ARGMAX);

  // Weights survive rst; the read above sees the pre-edge row.
  always_ff @(posedge clk) begin
    if (w_we && 32'(w_addr) < CLAUSEN)
      wmem[w_addr] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      scan_idx     <= '0;
      best_class   <= '0;
      best_sum     <= '0;
      result_valid <= 1'b0;
      pred_class   <= '0;
      pred_sum     <= '0;
      drop_err     <= 1'b0;
      for (int c = 0; c < CLASSN; c++) sums[c] <= '0;
    end else begin
      state <= state_n;
      if (img_rst) begin
        result_valid <= 1'b0;
        drop_err     <= 1'b0;
        scan_idx     <= '0;
        for (int c = 0; c < CLASSN; c++) sums[c] <= '0;
      end else begin
        if (clause_valid && state != ACCUM) drop_err <= 1'b1;
        unique case (state)
          ACCUM: begin
            scan_idx <= '0;
            if (clause_valid && clause_op)
              for (int c = 0; c < CLASSN; c++)
                sums[c] <= acc(sums[c], row[c*W_WIDTH +: W_WIDTH]);
          end
          ARGMAX: begin
            scan_idx <= scan_idx + 1'b1;
            // Strictly-greater replace keeps the lowest index on ties.
            if (scan_idx == '0 || sums[scan_idx] > best_sum) begin
              best_sum   <= sums[scan_idx];
              best_class <= scan_idx;
            end
          end
          DONE: begin
            // First DONE cycle publishes; later cycles wait for ready.
            if (!result_valid) begin
              result_valid <= 1'b1;
              pred_class   <= best_class;
              pred_sum     <= best_sum;
            end else if (result_ready) begin
              result_valid <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_class_sum_argmax.sv
// Directed bench for class_sum_argmax (SUM_WIDTH=8 build).
// Table-driven passes plus hand sequences for multi-cycle corners.
module tb_class_sum_argmax;

  localparam int CLASSN = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              img_rst;
  logic              clause_valid;
  logic              clause_op;
  logic [3:0]        clause_idx;
  logic              last_clause;
  logic              w_we;
  logic [3:0]        w_addr;
  logic [39:0]       w_data;
  logic              result_ready;
  logic              result_valid;
  logic [2:0]        pred_class;
  logic signed [7:0] pred_sum;
  logic              busy;
  logic              drop_err;

  int nchecks = 0;
  int nfail   = 0;

  class_sum_argmax #(
    .CLAUSEN(10), .CLASSN(CLASSN), .W_WIDTH(8), .SUM_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .img_rst(img_rst),
    .clause_valid(clause_valid), .clause_op(clause_op),
    .clause_idx(clause_idx), .last_clause(last_clause),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .result_ready(result_ready), .result_valid(result_valid),
    .pred_class(pred_class), .pred_sum(pred_sum),
    .busy(busy), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [39:0]      r0;
    logic [39:0]      r1;
    int               n;
    logic [2:0][3:0]  idx;
    logic [2:0]       op;
    int               ecls;
    int               esum;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [39:0] p5(int a, int b, int c, int d, int e);
    p5 = {8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic vec_t mk(logic [39:0] a, logic [39:0] b, int n,
                              int i0, bit o0, int i1, bit o1,
                              int i2, bit o2, int ec, int es);
    vec_t v;
    v.r0 = a; v.r1 = b; v.n = n;
    v.idx[0] = 4'(i0); v.idx[1] = 4'(i1); v.idx[2] = 4'(i2);
    v.op = {o2, o1, o0};
    v.ecls = ec; v.esum = es;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wr(int a, logic [39:0] d);
    w_we = 1'b1; w_addr = 4'(a); w_data = d;
    @(negedge clk);
    w_we = 1'b0;
  endtask

  task automatic imgrst();
    img_rst = 1'b1;
    @(negedge clk);
    img_rst = 1'b0;
  endtask

  task automatic cl(int i, bit op, bit last);
    clause_valid = 1'b1; clause_idx = 4'(i);
    clause_op = op; last_clause = last;
    @(negedge clk);
    clause_valid = 1'b0; clause_op = 1'b0; last_clause = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (!result_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack(string nm);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk({nm, " rv_drop"}, int'(result_valid), 0);
  endtask

  task automatic check_res(string nm, int lat, int elat, int ec, int es);
    chk({nm, " latency"}, lat, elat);
    chk({nm, " cls"}, int'(pred_class), ec);
    chk({nm, " sum"}, int'(pred_sum), es);
  endtask

  initial begin
    int lat;
    bit ok;
    rst = 1'b1; img_rst = 1'b0; clause_valid = 1'b0; clause_op = 1'b0;
    clause_idx = '0; last_clause = 1'b0; w_we = 1'b0; w_addr = '0;
    w_data = '0; result_ready = 1'b0;

    vecs[0] = mk(p5(1,2,3,4,5), '0, 1, 0,1, 0,0, 0,0, 4, 5);
    vecs[1] = mk(p5(3,3,0,0,0), '0, 2, 0,1, 1,1, 0,0, 0, 3);
    vecs[2] = mk(p5(-5,-3,-7,-4,-9), '0, 1, 0,1, 0,0, 0,0, 1, -3);
    vecs[3] = mk(p5(1,2,3,4,5), p5(10,0,0,0,0), 3,
                 0,0, 1,1, 0,1, 0, 11);
    vecs[4] = mk(p5(0,0,0,0,1), p5(50,0,0,0,0), 2,
                 12,1, 0,1, 0,0, 4, 1);
`ifdef CLASS_SUM_SAT_EN
    vecs[5] = mk(p5(-1,-1,127,-1,-1), '0, 2, 0,1, 0,1, 0,0, 2, 127);
    vecs[8] = mk(p5(-100,-100,-100,-100,-90),
                 p5(-100,-100,-100,-100,-90), 2,
                 0,1, 1,1, 0,0, 0, -128);
`else
    vecs[5] = mk(p5(-1,-1,127,-1,-1), '0, 2, 0,1, 0,1, 0,0, 0, -2);
    vecs[8] = mk(p5(-100,-100,-100,-100,-90),
                 p5(-100,-100,-100,-100,-90), 2,
                 0,1, 1,1, 0,0, 4, 76);
`endif
    vecs[6] = mk(p5(0,6,2,6,6), '0, 1, 0,1, 0,0, 0,0, 1, 6);
    vecs[7] = mk(p5(9,9,9,9,9), '0, 1, 0,0, 0,0, 0,0, 0, 0);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset rv", int'(result_valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset drop", int'(drop_err), 0);
    chk("reset cls", int'(pred_class), 0);
    chk("reset sum", int'(pred_sum), 0);

    for (int k = 0; k < 9; k++) begin
      wr(0, vecs[k].r0);
      wr(1, vecs[k].r1);
      imgrst();
      for (int j = 0; j < vecs[k].n; j++)
        cl(int'(vecs[k].idx[j]), vecs[k].op[j], j == vecs[k].n - 1);
      wait_res(lat);
      check_res($sformatf("vec%0d", k), lat, CLASSN + 1,
                vecs[k].ecls, vecs[k].esum);
      ack($sformatf("vec%0d", k));
    end

    // Clause during ARGMAX is dropped; hold result; img_rst clears flag.
    wr(0, p5(1,2,3,4,5));
    imgrst();
    chk("accum busy", int'(busy), 1);
    cl(0, 1'b1, 1'b1);
    cl(0, 1'b1, 1'b0);
    chk("drop set", int'(drop_err), 1);
    wait_res(lat);
    check_res("drop", lat + 1, CLASSN + 1, 4, 5);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(result_valid && pred_class == 3'd4 && pred_sum == 8'sd5))
        ok = 1'b0;
    end
    chk("hold stable", int'(ok), 1);
    ack("hold");
    chk("idle busy", int'(busy), 0);
    chk("drop sticky", int'(drop_err), 1);
    imgrst();
    chk("drop clear", int'(drop_err), 0);

    // Same-cycle write and read of row 0 uses the old weights.
    imgrst();
    clause_valid = 1'b1; clause_idx = 4'd0; clause_op = 1'b1;
    last_clause = 1'b1;
    w_we = 1'b1; w_addr = 4'd0; w_data = p5(0,0,9,0,0);
    @(negedge clk);
    clause_valid = 1'b0; clause_op = 1'b0; last_clause = 1'b0;
    w_we = 1'b0;
    wait_res(lat);
    check_res("rdwr old", lat, CLASSN + 1, 4, 5);
    ack("rdwr old");

    // img_rst wins over a coincident clause.
    imgrst();
    cl(0, 1'b1, 1'b0);
    img_rst = 1'b1; clause_valid = 1'b1; clause_idx = 4'd0;
    clause_op = 1'b1;
    @(negedge clk);
    img_rst = 1'b0; clause_valid = 1'b0; clause_op = 1'b0;
    cl(0, 1'b1, 1'b1);
    wait_res(lat);
    check_res("imgrst ovr", lat, CLASSN + 1, 2, 9);
    ack("imgrst ovr");

    // rst mid-ACCUM abandons the pass but keeps weights.
    imgrst();
    repeat (3) cl(0, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst rv", int'(result_valid), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst cls", int'(pred_class), 0);
    chk("rst sum", int'(pred_sum), 0);
    chk("rst drop", int'(drop_err), 0);
    imgrst();
    cl(0, 1'b1, 1'b1);
    wait_res(lat);
    check_res("after rst", lat, CLASSN + 1, 2, 9);
    ack("after rst");

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule

// File: doc/class_sum_argmax.md
CLASS_SUM_ARGMAX -- requirements
Module: class_sum_argmax

Interface
REQ-001 The block SHALL have parameter CLAUSEN, default 10, meaning number of clauses per image pass.
REQ-002 The block SHALL have parameter CLASSN, default 5, meaning number of classes.
REQ-003 The block SHALL have parameter W_WIDTH, default 8, meaning signed clause-weight width.
REQ-004 The block SHALL have parameter SUM_WIDTH, default 16, meaning signed class-sum width.
REQ-005 The block SHALL have port clk, input, 1, clock; reset rst, synchronous, active-high; clock clk.
REQ-006 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port img_rst, input, 1, start-of-image pulse.
REQ-008 The block SHALL have port clause_valid, input, 1, final clause_op of conv chain valid.
REQ-009 The block SHALL have port clause_op, input, 1, OR-reduced clause output from last conv stage.
REQ-010 The block SHALL have port clause_idx, input, $clog2(CLAUSEN), clause being reported.
REQ-011 The block SHALL have port last_clause, input, 1, qualifies clause_valid as final clause of image.
REQ-012 The block SHALL have port w_we, input, 1, weight write strobe.
REQ-013 The block SHALL have port w_addr, input, $clog2(CLAUSEN), weight row (clause index).
REQ-014 The block SHALL have port w_data, input, CLASSN*W_WIDTH, signed weights, class c at bits [c*W_WIDTH +: W_WIDTH].
REQ-015 The block SHALL have port result_ready, input, 1, consumer accepts result.
REQ-016 The block SHALL have port result_valid, output, 1, pred_class/pred_sum valid.
REQ-017 The block SHALL have port pred_class, output, $clog2(CLASSN), winning class index.
REQ-018 The block SHALL have port pred_sum, output, SUM_WIDTH, winning class sum, signed.
REQ-019 The block SHALL have port busy, output, 1, high in ACCUM or ARGMAX.
REQ-020 The block SHALL have port drop_err, output, 1, sticky: clause_valid arrived outside ACCUM.

Function
REQ-021 The FSM SHALL have states IDLE, ACCUM, ARGMAX, DONE.
REQ-022 From any state, img_rst SHALL clear all class sums to 0 and enter ACCUM on the next edge; img_rst overrides coincident clause_valid.
REQ-023 In ACCUM, clause_valid with clause_op=1 SHALL add weight[clause_idx][c] (sign-extended) to sum[c] for all c; sums update on the next edge (latency 1).
REQ-024 In ACCUM, clause_valid with clause_op=0 SHALL leave sums unchanged.
REQ-025 In ACCUM, clause_valid with last_clause=1 SHALL perform its accumulation and enter ARGMAX with scan index 0.
REQ-026 ARGMAX SHALL scan one class per cycle, index 0 to CLASSN-1, lasting exactly CLASSN cycles, then enter DONE.
REQ-027 Comparison SHALL be signed; ties SHALL resolve to the lowest class index (strictly-greater replaces).
REQ-028 DONE SHALL assert result_valid with stable pred_class/pred_sum until result_ready is sampled high, then enter IDLE and deassert result_valid next cycle.
REQ-029 For clause_valid with last_clause on edge N, result_valid SHALL rise at edge N+1+CLASSN.
REQ-030 clause_valid in IDLE, ARGMAX or DONE SHALL be ignored and set drop_err; drop_err clears only on rst or img_rst.
REQ-031 Weight writes SHALL be accepted in any state; same-cycle write and accumulate read of the same row SHALL use the old weight.
REQ-032 clause_idx >= CLAUSEN SHALL be treated as a zero-weight clause; w_addr >= CLAUSEN writes SHALL be discarded.

Reset
REQ-033 rst SHALL set state IDLE, sums 0, result_valid 0, pred_class 0, pred_sum 0, busy 0, drop_err 0.
REQ-034 rst SHALL NOT clear the weight array; rst mid-ACCUM or mid-ARGMAX SHALL abandon the pass with no result.

Configuration
REQ-035 With CLASS_SUM_SAT_EN defined, accumulation SHALL saturate at +2^(SUM_WIDTH-1)-1 and -2^(SUM_WIDTH-1).
REQ-036 Without CLASS_SUM_SAT_EN, accumulation SHALL wrap modulo 2^SUM_WIDTH.

Verification
REQ-037 Weights row0={1,2,3,4,5}, img_rst, clause 0 op=1 last -> after 1+5 cycles result_valid, pred_class=4, pred_sum=5.
REQ-038 Rows 0,1 = {3,3,0,0,0} and {0,0,0,0,0}, clauses 0,1 op=1 -> pred_class=0 (tie), pred_sum=3.
REQ-039 Row0 class2 weight +127, SUM_WIDTH=8, 2 hits -> 127 with CLASS_SUM_SAT_EN, -2 without.
REQ-040 clause_valid during ARGMAX -> drop_err=1, sums and result unchanged; img_rst clears drop_err.
REQ-041 result_ready held low 10 cycles in DONE -> result_valid and outputs stable; ready high -> IDLE, result_valid=0 next cycle.
REQ-042 rst asserted mid-ACCUM after 3 hits -> outputs at reset values, new pass starts sums from 0, weights retained.
